// File: rtl/flash_spi_pkg.sv
// rtl/flash_spi_pkg.sv - shared opcodes, FSM state type and byte-order helper for the SPI flash controller
package flash_spi_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        WREN,
        GAP,
        CMD,
        WDATA,
        RDATA,
        DONE
    } state_t;

    // Data travels little-endian on the wire but each byte goes MSB-first,
    // so a byte swap turns the word into a plain MSB-first shift image.
    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK divider producing mode-0 clock plus rise/fall/stop strobes
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic stop
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = en && (cnt == LAST);
    assign rise = tick && !sck && !hold;
    assign fall = tick && sck;
    // With hold set, the phase that would have been a rise becomes the
    // trailing low phase before chip select is released.
    assign stop = tick && !sck && hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (rise) begin
                sck <= 1'b1;
            end else if (fall) begin
                sck <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/flash_spi_ctrl.sv
// rtl/flash_spi_ctrl.sv - word read/write bridge from an MMU request port to a mode-0 SPI NOR flash
module flash_spi_ctrl
    import flash_spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP);
    localparam logic [GW-1:0] DONE_LAST = GW'(CS_GAP - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [31:0] wdata_q;
    logic [23:0] addr_q;
    logic        we_q;
    logic        tail;
    logic [5:0]  bit_cnt;
    logic [GW-1:0] gap_cnt;

    logic sck_rise;
    logic sck_fall;
    logic sck_stop;
    logic accept;
    logic misaligned;
    logic last_bit;

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk (clk),
        .rst (rst),
        .en  (!spi_cs_n),
        .hold(tail),
        .sck (spi_sck),
        .rise(sck_rise),
        .fall(sck_fall),
        .stop(sck_stop)
    );

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        accept     = req_valid && (state == IDLE);
        misaligned = (req_addr[1:0] != 2'b00);
        last_bit   = sck_fall && (bit_cnt == ((state == WREN) ? 6'd7 : 6'd31));
        state_nx   = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_nx = ERR;
                    end else if (req_we) begin
                        state_nx = WREN;
                    end else begin
                        state_nx = CMD;
                    end
                end
            end
            ERR:   state_nx = IDLE;
            WREN:  if (sck_stop) state_nx = GAP;
            GAP:   if (gap_cnt >= GAP_LAST) state_nx = CMD;
            CMD:   if (last_bit) state_nx = we_q ? WDATA : RDATA;
            WDATA: if (sck_stop) state_nx = DONE;
            RDATA: if (sck_stop) state_nx = DONE;
            // DONE lingers so the next frame cannot start before chip select
            // has been high for the minimum gap.
            DONE:  if (gap_cnt >= DONE_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            tail      <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                busy <= 1'b1;
            end else if (rsp_valid) begin
                busy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        if (!misaligned) begin
                            spi_cs_n <= 1'b0;
                            bit_cnt  <= '0;
                            tx       <= req_we ? {OP_WREN, 24'h0} : {OP_READ, req_addr};
                            spi_mosi <= req_we ? OP_WREN[7] : OP_READ[7];
                        end
                    end
                end
                ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        spi_cs_n <= 1'b0;
                        bit_cnt  <= '0;
                        tx       <= {OP_PP, addr_q};
                        spi_mosi <= OP_PP[7];
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    if (gap_cnt < DONE_LAST) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                WREN, CMD, WDATA, RDATA: begin
                    if (sck_rise && (state == RDATA)) begin
                        rx <= {rx[30:0], spi_miso};
                    end
                    if (sck_fall) begin
                        if (!last_bit) begin
                            bit_cnt  <= bit_cnt + 6'd1;
                            tx       <= {tx[30:0], 1'b0};
                            spi_mosi <= tx[30];
                        end else if (state == CMD) begin
                            // Command phase flows straight into data within the same frame.
                            bit_cnt  <= '0;
                            if (we_q) begin
                                tx       <= bswap(wdata_q);
                                spi_mosi <= wdata_q[7];
                            end else begin
                                spi_mosi <= 1'b0;
                            end
                        end else begin
                            tail     <= 1'b1;
                            spi_mosi <= 1'b0;
                        end
                    end
                    if (sck_stop) begin
                        spi_cs_n <= 1'b1;
                        tail     <= 1'b0;
                        gap_cnt  <= GW'(1);
                        if (state != WREN) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= (state == RDATA) ? bswap(rx) : 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
